mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width; only 32 is required to work.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port src_a  input  32  operand A (multiplicand/dividend), driven from register-file RD1.
REQ-007 SHALL have port src_b  input  32  operand B (multiplier/divisor), driven from register-file RD2.
REQ-008 SHALL have port hilo_we  input  1  direct HI/LO write enable (MTHI/MTLO).
REQ-009 SHALL have port hilo_sel  input  1  direct-write target: 1 = HI, 0 = LO.
REQ-010 SHALL have port hilo_wd  input  32  direct-write data.
REQ-011 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse; result committed.
REQ-013 SHALL have port div_by_zero  output  1  valid with done; high when a DIV/DIVU had src_b = 0.
REQ-014 SHALL have ports hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, FINISH.
REQ-016 SHALL, in IDLE with start = 1 at a posedge (edge 0), latch op, |src_a|, |src_b| and the result signs, clear the iteration counter, and enter CALC.
REQ-017 SHALL execute one shift-add (multiply) or restoring shift-subtract (divide) step per cycle in CALC, for exactly 32 steps (edges 1..32), then enter FINISH at edge 33.
REQ-018 SHALL, at the FINISH edge (edge 34), apply sign correction, write HI/LO, pulse done for the following cycle, and return to IDLE.
REQ-019 SHALL make hi/lo hold the new result, with done = 1, in the cycle after edge 34; start is accepted again in that same cycle.
REQ-020 SHALL, for MULT/MULTU, write the full 64-bit product: HI = upper 32 bits, LO = lower 32 bits; MULT is two's-complement signed.
REQ-021 SHALL, for DIV/DIVU, write LO = quotient and HI = remainder; DIV truncates toward zero, and the remainder takes the sign of the dividend.
REQ-022 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, give LO = 0x80000000 and HI = 0x00000000, with no error flag.
REQ-023 SHALL, for DIV/DIVU with src_b = 0, go from IDLE directly to FINISH, then pulse done with div_by_zero = 1 at the next edge, leaving HI/LO unchanged.
REQ-024 SHALL ignore start while busy = 1; the operation in flight is unaffected.
REQ-025 SHALL perform hilo_we writes only in IDLE, at the posedge, to the register named by hilo_sel; hilo_we while busy is dropped.
REQ-026 SHALL give start priority when start and hilo_we are both high in IDLE; the direct write is dropped.
REQ-027 SHALL hold done and div_by_zero at 0 in every cycle except the single done cycle.

Reset
REQ-028 SHALL, while rst_n = 0 and irrespective of clk, force state = IDLE, busy = 0, done = 0, div_by_zero = 0, hi = 0, lo = 0, and the counter and datapath registers to 0.
REQ-029 SHALL, on reset asserted mid-operation, abandon the operation with no done pulse; the first start after release behaves exactly per REQ-016..019.

Structure
REQ-030 SHALL take op encodings, FSM state encoding and ITERATIONS = 32 from the shared package mdu_pkg.
REQ-031 SHALL place the combinational sign handling (operand absolute value, result negation) in one sub-module, mdu_sign_fix; the FSM, counter and datapath stay in mult_div_unit.

Verification
REQ-032 SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001, done high in the cycle after edge 34, busy high in cycles 1..34.
REQ-033 SHALL cover: MULT 0xFFFFFFFD (-3) x 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; then DIV 0xFFFFFFF9 (-7) / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
REQ-034 SHALL cover: MTLO 0x12345678 in IDLE, then DIVU 100 / 0 -> done and div_by_zero high two edges after start; LO stays 0x12345678.
REQ-035 SHALL cover: DIVU 100 / 7 started, then start (MULTU 2 x 3) and hilo_we pulsed at edge 5 -> both ignored; final LO = 14, HI = 2.
REQ-036 SHALL cover: rst_n low mid-calculation (edge 10) -> busy = 0, hi = lo = 0 immediately with no done pulse; after release, MULTU 5 x 6 -> LO = 30 at edge 34.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, iteration count.
package mdu_pkg;

  localparam int unsigned ITERATIONS = 32;
  localparam int unsigned CntW       = $clog2(ITERATIONS + 1);

  typedef enum logic [1:0] {
    OpMult  = 2'b00,
    OpMultu = 2'b01,
    OpDiv   = 2'b10,
    OpDivu  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCalc   = 2'd1,
    StFinish = 2'd2
  } state_e;

  function automatic logic is_div_op(input op_e op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

  function automatic logic is_signed_op(input op_e op);
    return (op == OpMult) || (op == OpDiv);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational sign handling: operand magnitudes on the way in, result negation on the way out.
module mdu_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic [WIDTH-1:0]   abs_a,
  output logic [WIDTH-1:0]   abs_b,
  output logic               neg_res,
  output logic               neg_rem,
  input  logic               div_op,
  input  logic               neg_res_in,
  input  logic               neg_rem_in,
  input  logic [2*WIDTH-1:0] raw,
  output logic [WIDTH-1:0]   res_hi,
  output logic [WIDTH-1:0]   res_lo
);

  logic neg_a;
  logic neg_b;
  logic [2*WIDTH-1:0] prod;

  // Magnitudes and result signs; quotient/product sign is the XOR, remainder follows the dividend.
  always_comb begin
    neg_a   = signed_op & src_a[WIDTH-1];
    neg_b   = signed_op & src_b[WIDTH-1];
    abs_a   = neg_a ? -src_a : src_a;
    abs_b   = neg_b ? -src_b : src_b;
    neg_res = neg_a ^ neg_b;
    neg_rem = neg_a;
    prod    = neg_res_in ? -raw : raw;
    if (div_op) begin
      res_lo = neg_res_in ? -raw[WIDTH-1:0] : raw[WIDTH-1:0];
      res_hi = neg_rem_in ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers (32 cycles per operation).
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] hilo_wd,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import mdu_pkg::*;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic               dbz_pend_q, dbz_pend_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, dbz_q, dbz_d;

  op_e              op_in;
  logic [WIDTH-1:0] abs_a, abs_b, res_hi, res_lo;
  logic             neg_res, neg_rem;
  logic [WIDTH:0]   mul_sum, div_diff;

  assign op_in = op_e'(op);

  mdu_sign_fix #(
    .WIDTH(WIDTH)
  ) u_sign_fix (
    .signed_op  (is_signed_op(op_in)),
    .src_a      (src_a),
    .src_b      (src_b),
    .abs_a      (abs_a),
    .abs_b      (abs_b),
    .neg_res    (neg_res),
    .neg_rem    (neg_rem),
    .div_op     (is_div_op(op_q)),
    .neg_res_in (neg_res_q),
    .neg_rem_in (neg_rem_q),
    .raw        (acc_q),
    .res_hi     (res_hi),
    .res_lo     (res_lo)
  );

  // Next-state: FSM, iteration counter, shift-add / restoring-divide datapath, HI/LO writes.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dbz_pend_d = dbz_pend_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;
    // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
    div_diff   = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d      = op_in;
          a_d       = abs_a;
          b_d       = abs_b;
          neg_res_d = neg_res;
          neg_rem_d = neg_rem;
          cnt_d     = '0;
          acc_d     = is_div_op(op_in) ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
          if (is_div_op(op_in) && (src_b == '0)) begin
            dbz_pend_d = 1'b1;
            state_d    = StFinish;
          end else begin
            dbz_pend_d = 1'b0;
            state_d    = StCalc;
          end
        end else if (hilo_we) begin
          if (hilo_sel) hi_d = hilo_wd;
          else          lo_d = hilo_wd;
        end
      end
      StCalc: begin
        if (cnt_q == CntW'(ITERATIONS)) begin
          state_d = StFinish;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (is_div_op(op_q)) begin
            if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else                  acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
          end else begin
            if (acc_q[0]) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
          end
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        dbz_d   = dbz_pend_q;
        state_d = StIdle;
        if (!dbz_pend_q) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= OpMult;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_pend_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dbz_pend_q <= dbz_pend_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        hilo_we = 1'b0;
  logic        hilo_sel = 1'b0;
  logic [31:0] hilo_wd = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .hilo_we     (hilo_we),
    .hilo_sel    (hilo_sel),
    .hilo_wd     (hilo_wd),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result {hi, lo}; division by zero leaves the old HI/LO.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] oh,
                                        input logic [31:0] ol);
    longint sa, sb, p, q, r;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin p = sa * sb; return p; end
      2'b01: begin up = {32'd0, a} * {32'd0, b}; return up; end
      2'b10: begin
        if (b == 0) return {oh, ol};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {oh, ol};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic mt(input logic sel, input logic [31:0] data);
    hilo_we = 1'b1; hilo_sel = sel; hilo_wd = data;
    @(posedge clk); #1;
    hilo_we = 1'b0;
    if (sel) m_hi = data; else m_lo = data;
    check(sel ? "mthi" : "mtlo", {hi, lo}, {m_hi, m_lo});
  endtask

  // Launch one op; returns at #1 after the done edge (the done cycle).
  // inject: pulse start+hilo_we so they are sampled at edge 5. with_we: hilo_we alongside start.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit inject, input bit with_we);
    logic [63:0] exp;
    bit ok;
    bit dbz;
    dbz = o[1] && (b == 0);
    exp = model(o, a, b, m_hi, m_lo);
    start = 1'b1; op = o; src_a = a; src_b = b;
    if (with_we) begin hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wd = 32'hA5A5_A5A5; end
    @(posedge clk); #1;
    start = 1'b0; hilo_we = 1'b0;
    if (dbz) begin
      check({tag, "_busy0"}, {busy, done, div_by_zero}, 3'b100);
      @(posedge clk); #1;
      check({tag, "_dbzflags"}, {busy, done, div_by_zero}, 3'b011);
    end else begin
      ok = 1;
      for (int k = 0; k < 34; k++) begin
        if (!(busy === 1'b1 && done === 1'b0 && div_by_zero === 1'b0)) ok = 0;
        if (inject && k == 4) begin
          start = 1'b1; op = 2'b01; src_a = 2; src_b = 3;
          hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wd = 32'hDEAD_BEEF;
        end
        if (inject && k == 5) begin start = 1'b0; hilo_we = 1'b0; end
        if (k < 33) begin @(posedge clk); #1; end
      end
      check({tag, "_busywin"}, 64'(ok), 64'd1);
      @(posedge clk); #1;
      check({tag, "_flags"}, {busy, done, div_by_zero}, 3'b010);
    end
    check({tag, "_hilo"}, {hi, lo}, exp);
    {m_hi, m_lo} = exp;
  endtask

  initial begin
    bit saw_done;
    logic [1:0] ro;
    logic [31:0] ra, rb;

    // Reset state, before and after a clock edge with reset held
    #3;
    check("rst_pre", {busy, done, div_by_zero, hi, lo}, '0);
    #4;
    check("rst_post", {busy, done, div_by_zero, hi, lo}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    check("multu_max_exact", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 0, 0);
    check("mult_neg_exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
    check("div_neg_exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check("div_ovf_exact", {hi, lo}, 64'h0000_0000_8000_0000);

    @(posedge clk); #1;
    mt(1'b0, 32'h1234_5678);
    run_op("divu_zero", 2'b11, 32'd100, 32'd0, 0, 0);
    check("divu_zero_lo", 64'(lo), 64'h1234_5678);
    @(posedge clk); #1;
    check("done_drop", {done, div_by_zero}, 2'b00);

    run_op("divu_inject", 2'b11, 32'd100, 32'd7, 1, 0);
    check("divu_inject_exact", {hi, lo}, {32'd2, 32'd14});

    // start beats a simultaneous direct write
    run_op("start_prio", 2'b01, 32'd9, 32'd11, 0, 1);
    check("start_prio_lo", 64'(lo), 64'd99);

    // Reset in the middle of a calculation
    start = 1'b1; op = 2'b01; src_a = 32'h1357_9BDF; src_b = 32'h2468_ACE0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst", {busy, done, div_by_zero, hi, lo}, '0);
    saw_done = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) saw_done = 1;
    end
    check("midrst_nodone", 64'(saw_done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;
    run_op("after_rst", 2'b01, 32'd5, 32'd6, 0, 0);
    check("after_rst_lo", 64'(lo), 64'd30);

    // Random operations, including zero and all-ones divisors
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
        mt(1'($urandom_range(0, 1)), $urandom);
      end
      run_op("rand", ro, ra, rb, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
